spi_reg_responder: RTL

SPI mode-0 slave that answers the SoC's `spi0` master with a MAX3421E-style register protocol. It lets the USB host software be brought up against a local 32 × 8 register file instead of the physical USB chip. It is clocked from the fabric clock, oversamples SCLK/SS_n/MOSI, and exposes a local register port plus an interrupt line. It sits between the `spi0_*` pins of the SoC and fabric logic that emulates or monitors the USB controller.

---
 rtl/spi_reg_responder_if.sv | 23 ++
 rtl/spi_reg_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/spi_reg_responder_if.sv
// spi_reg_responder_if: SPI pins plus local register port and commit/irq outputs
interface spi_reg_responder_if;
  logic       SCLK;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_we;
  logic [7:0] loc_rdata;
  logic       wr_strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       irq;
  modport slave (
    input  SCLK, SS_n, MOSI, loc_addr, loc_wdata, loc_we,
    output MISO, loc_rdata, wr_strobe, wr_addr, wr_data, irq
  );
  modport master (
    output SCLK, SS_n, MOSI, loc_addr, loc_wdata, loc_we,
    input  MISO, loc_rdata, wr_strobe, wr_addr, wr_data, irq
  );
endinterface

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: oversampling SPI mode-0 slave exposing a 32x8 register file
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_REG     = 25,
  parameter int IEN_REG     = 26
) (
  input logic Clk,
  input logic Reset,
  spi_reg_responder_if.slave bus
);
  localparam logic [4:0] IRQ_A = 5'(IRQ_REG);
  localparam logic [4:0] IEN_A = 5'(IEN_REG);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_dly_q, sclk_dly_d, ss_dly_q, ss_dly_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shin_q, shin_d, shout_q, shout_d;
  logic [4:0] addr_q, addr_d;
  logic wr_q, wr_d, miso_q, miso_d;
  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];
  logic wr_strobe_q, wr_strobe_d, irq_q, irq_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d, loc_rdata_q, loc_rdata_d;
  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall, commit;
  logic [7:0] rx_byte;
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
    sclk_rise   = sclk_s & ~sclk_dly_q;
    sclk_fall   = ~sclk_s & sclk_dly_q;
    ss_rise     = ss_s & ~ss_dly_q;
    ss_fall     = ~ss_s & ss_dly_q;
    rx_byte     = {shin_q, mosi_s};
  end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shin_d    = shin_q;
    shout_d   = shout_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    miso_d    = miso_q;
    commit    = 1'b0;
    if (state_q == IDLE) begin
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
      if (ss_fall) begin
        state_d = CMD;
        {miso_d, shout_d} = regs_q[IRQ_A];
      end
    end else if (ss_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      shin_d    = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7 && state_q == CMD) begin
        state_d = DATA;
        addr_d  = rx_byte[7:3];
        wr_d    = rx_byte[1];
      end
      commit = bit_cnt_q == 3'd7 && state_q == DATA && wr_q;
    end else if (sclk_fall) begin
      // byte boundary of a read frame reloads the addressed register
      {miso_d, shout_d} = (state_q == DATA && bit_cnt_q == 3'd0 && !wr_q) ? regs_q[addr_q] : {shout_q, 1'b0};
    end
  end
  always_comb begin
    regs_d = regs_q;
    if (bus.loc_we)
      regs_d[bus.loc_addr] = bus.loc_addr == IRQ_A ? regs_q[IRQ_A] | bus.loc_wdata : bus.loc_wdata;
    // a flag set locally in the same cycle as a W1C survives the clear
    if (commit)
      regs_d[addr_q] = addr_q == IRQ_A
        ? (regs_q[IRQ_A] & ~rx_byte) | (bus.loc_we && bus.loc_addr == IRQ_A ? bus.loc_wdata : 8'h00)
        : rx_byte;
    wr_strobe_d = commit;
    wr_addr_d   = commit ? addr_q : wr_addr_q;
    wr_data_d   = commit ? rx_byte : wr_data_q;
    loc_rdata_d = regs_q[bus.loc_addr];
    irq_d       = |(regs_q[IRQ_A] & regs_q[IEN_A]);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shin_q      <= 7'd0;
      shout_q     <= 7'd0;
      addr_q      <= 5'd0;
      wr_q        <= 1'b0;
      miso_q      <= 1'b0;
      regs_q      <= '{default: 8'h00};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      loc_rdata_q <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      bit_cnt_q   <= bit_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      loc_rdata_q <= loc_rdata_d;
      irq_q       <= irq_d;
    end
  end
  assign bus.MISO      = miso_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.loc_rdata = loc_rdata_q;
  assign bus.irq       = irq_q;
endmodule
